// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder.
//   sccb_state_t : protocol FSM states
//   OV7670_WR_ID : default 8-bit write ID of the emulated camera
//   OV7670_RD_ID : matching read ID (write ID with bit 0 set)
//   id_match     : compares the 7-bit address field of an ID byte
package sccb_pkg;

  localparam logic [7:0] OV7670_WR_ID = 8'h42;
  localparam logic [7:0] OV7670_RD_ID = 8'h43;

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StIdAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataNa,
    StIgnore
  } sccb_state_t;

  // Bit 0 is the read/write flag and takes no part in addressing.
  function automatic logic id_match(logic [7:0] id, logic [7:0] dev);
    return id[7:1] == dev[7:1];
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises the asynchronous scl/sda pins into the clk domain and decodes bus events.
// Ports:
//   clk, n_rst       : system clock, synchronous active-low reset
//   scl_in, sda_in   : raw bus lines from the pins
//   sda              : synchronised sda level (for data sampling)
//   scl_rise/fall    : one-cycle pulses on synchronised scl edges
//   start/stop       : one-cycle pulses for sda fall/rise while scl is high
// An event becomes visible to a registered consumer SYNC_STAGES+1 clk after the pin change.
// SYNC_STAGES must be at least 2.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  // Fills with ones after reset; events are gated until the chains hold real pin values,
  // so the idle-high reset value of the chains never produces a spurious edge or START.
  logic [SYNC_STAGES:0]   fill_q;

  logic scl_s;
  logic sda_s;
  logic valid;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign valid = fill_q[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      fill_q     <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      fill_q     <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sda      = sda_s;
  assign scl_rise = valid & scl_s & ~scl_prev_q;
  assign scl_fall = valid & ~scl_s & scl_prev_q;
  assign start    = valid & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = valid & scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder emulating an OV7670-style register port.
// Ports:
//   clk, n_rst : system clock (>= 16x SCL), synchronous active-low reset
//   scl_in     : bus clock from the pin (asynchronous)
//   sda_in     : bus data from the pin (asynchronous)
//   sda_oe     : 1 = pull sda low; the top level builds the open-drain inout
//   active     : high from an accepted ID byte until STOP or reset
//   reg_wr     : one-cycle write strobe, reg_addr/reg_wdata valid with it
//   reg_addr   : current register address (sub-address, auto-incremented)
//   reg_wdata  : write data
//   reg_rdata  : read data for reg_addr, valid 1 clk after reg_addr changes
//   id_miss    : one-cycle pulse when an ID byte does not match DEV_ID
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID      = OV7670_WR_ID,
  parameter bit          ACK_EN      = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       active,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       id_miss
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk     (clk),
    .n_rst   (n_rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  sccb_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  // ACK states: 0 = waiting for the fall that starts the 9th bit, 1 = waiting for its end.
  // RDATA: set after the 8th rise. RDATA_NA: set after the master acknowledged.
  logic        phase_q, phase_d;
  logic [7:0]  shift_q, shift_d;
  logic        rnw_q, rnw_d;
  logic        first_q, first_d;
  logic        oe_q, oe_d;
  logic        active_q, active_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        miss_q, miss_d;

  logic [7:0]  byte_in;
  logic        byte_done;

  assign byte_in   = {shift_q[6:0], sda};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    rnw_d     = rnw_q;
    first_d   = first_q;
    oe_d      = oe_q;
    active_d  = active_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    miss_d    = 1'b0;

    if (stop) begin
      state_d  = StIdle;
      oe_d     = 1'b0;
      active_d = 1'b0;
      phase_d  = 1'b0;
    end else if (start) begin
      // Repeated START is legal; any partial byte is dropped here.
      state_d   = StId;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
          oe_d = 1'b0;
        end

        StId, StSub, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            phase_d = 1'b0;
            if (state_q == StId) begin
              if (id_match(byte_in, DEV_ID)) begin
                active_d = 1'b1;
                rnw_d    = byte_in[0];
                state_d  = StIdAck;
              end else begin
                miss_d  = 1'b1;
                state_d = StIgnore;
              end
            end else if (state_q == StSub) begin
              addr_d  = byte_in;
              first_d = 1'b1;
              state_d = StSubAck;
            end else begin
              // Later bytes advance the address before their own write.
              if (!first_q) begin
                addr_d = addr_q + 8'd1;
              end
              first_d = 1'b0;
              wdata_d = byte_in;
              wr_d    = 1'b1;
              state_d = StWdataAck;
            end
          end
        end

        StIdAck, StSubAck, StWdataAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = ACK_EN;
              phase_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              oe_d      = 1'b0;
              if (state_q == StIdAck && rnw_q) begin
                shift_d = reg_rdata;
                oe_d    = ~reg_rdata[7];
                state_d = StRdata;
              end else if (state_q == StIdAck) begin
                state_d = StSub;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end

        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (phase_q) begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              state_d = StRdataNa;
            end else begin
              // Rotate rather than shift: the wrapped bit is never driven.
              shift_d = {shift_q[6:0], shift_q[7]};
              oe_d    = ~shift_q[6];
            end
          end
        end

        StRdataNa: begin
          if (scl_rise && !phase_q) begin
            if (sda) begin
              state_d = StIgnore;
            end else begin
              addr_d  = addr_q + 8'd1;
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            shift_d   = reg_rdata;
            oe_d      = ~reg_rdata[7];
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = StRdata;
          end
        end

        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      phase_q   <= 1'b0;
      shift_q   <= 8'h00;
      rnw_q     <= 1'b0;
      first_q   <= 1'b0;
      oe_q      <= 1'b0;
      active_q  <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      wr_q      <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      rnw_q     <= rnw_d;
      first_q   <= first_d;
      oe_q      <= oe_d;
      active_q  <= active_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      miss_q    <= miss_d;
    end
  end

  assign sda_oe    = oe_q;
  assign active    = active_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign id_miss   = miss_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bus master drives scl/sda (wired-AND with sda_oe), a small register
// bank answers reg_rdata, and monitors log writes, ID misses and cycles with sda pulled low.
module tb_sccb_target;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       active;
  logic       reg_wr;
  logic       id_miss;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign scl_in    = scl_m;
  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = (reg_addr == 8'h0A) ? 8'h76 : (reg_addr ^ 8'hA5);

  sccb_target #(
    .DEV_ID     (8'h42),
    .ACK_EN     (1'b1),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .active   (active),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .id_miss  (id_miss)
  );

  // Monitors
  logic [7:0] wr_a [64];
  logic [7:0] wr_d [64];
  int         wr_n = 0;
  int         wr_long = 0;
  int         miss_n = 0;
  int         oe_n = 0;
  logic       wr_prev = 1'b0;

  always @(posedge clk) begin
    wr_prev <= reg_wr;
    if (reg_wr) begin
      wr_a[wr_n[5:0]] <= reg_addr;
      wr_d[wr_n[5:0]] <= reg_wdata;
      wr_n <= wr_n + 1;
      if (wr_prev) wr_long <= wr_long + 1;
    end
    if (id_miss) miss_n <= miss_n + 1;
    if (sda_oe) oe_n <= oe_n + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Quarter SCL period: 8 clk, so SCL = clk/32.
  task automatic q();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
    end
  endtask

  // ack = sda_oe sampled mid-high of the 9th bit.
  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    ack = sda_oe; q();
    scl_m = 0; q();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b, output logic na_oe);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b[i] = ~sda_oe; q();
      scl_m = 1'b0; q();
    end
    sda_m = nack; q();
    scl_m = 1'b1; q();
    na_oe = sda_oe; q();
    scl_m = 1'b0; q();
  endtask

  task automatic write_txn(input logic [7:0] id, input logic [7:0] sub, input int nd,
                           input logic [7:0] d0, input logic [7:0] d1, input logic exp_ack,
                           input string tag);
    logic a;
    bus_start();
    send_byte(id, a);
    check({tag, "_id_ack"}, a, exp_ack);
    check({tag, "_active"}, active, exp_ack);
    send_byte(sub, a);
    check({tag, "_sub_ack"}, a, exp_ack);
    if (nd > 0) begin
      send_byte(d0, a);
      check({tag, "_d0_ack"}, a, exp_ack);
    end
    if (nd > 1) begin
      send_byte(d1, a);
      check({tag, "_d1_ack"}, a, exp_ack);
    end
    bus_stop();
    q();
    check({tag, "_active_after_stop"}, active, 1'b0);
  endtask

  typedef struct {
    logic [7:0] id;
    logic [7:0] sub;
    int         nd;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nwr;
    logic [7:0] a0;
    logic [7:0] w0;
    logic [7:0] a1;
    logic [7:0] w1;
    logic       ack;
    logic [7:0] addr_end;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic       a;
    logic       na;
    logic [7:0] rb;
    int         wb;
    int         mb;
    int         ob;

    vecs[0] = '{8'h42, 8'h12, 1, 8'h80, 8'h00, 1, 8'h12, 8'h80, 8'h00, 8'h00, 1'b1, 8'h12};
    vecs[1] = '{8'h42, 8'hFF, 2, 8'h11, 8'h22, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 1'b1, 8'h00};
    vecs[2] = '{8'h60, 8'h12, 1, 8'h80, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{8'h42, 8'h7F, 2, 8'hA5, 8'h5A, 2, 8'h7F, 8'hA5, 8'h80, 8'h5A, 1'b1, 8'h80};
    vecs[4] = '{8'h40, 8'h33, 1, 8'h44, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h80};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_id_miss", id_miss, 1'b0);
    n_rst = 1'b1;
    q();

    // Write transactions from the table
    for (int i = 0; i < 5; i++) begin
      wb = wr_n;
      mb = miss_n;
      ob = oe_n;
      write_txn(vecs[i].id, vecs[i].sub, vecs[i].nd, vecs[i].d0, vecs[i].d1, vecs[i].ack,
                $sformatf("v%0d", i));
      check($sformatf("v%0d_wr_count", i), wr_n - wb, vecs[i].nwr);
      if (vecs[i].nwr > 0) begin
        check($sformatf("v%0d_wr0_addr", i), wr_a[6'(wb)], vecs[i].a0);
        check($sformatf("v%0d_wr0_data", i), wr_d[6'(wb)], vecs[i].w0);
      end
      if (vecs[i].nwr > 1) begin
        check($sformatf("v%0d_wr1_addr", i), wr_a[6'(wb + 1)], vecs[i].a1);
        check($sformatf("v%0d_wr1_data", i), wr_d[6'(wb + 1)], vecs[i].w1);
      end
      check($sformatf("v%0d_id_miss", i), miss_n - mb, vecs[i].ack ? 0 : 1);
      if (!vecs[i].ack) check($sformatf("v%0d_oe_quiet", i), oe_n - ob, 0);
      check($sformatf("v%0d_addr_end", i), reg_addr, vecs[i].addr_end);
    end

    // Read: set address 0A, read 76 with master ACK, then AE from 0B with NA
    wb = wr_n;
    write_txn(8'h42, 8'h0A, 0, 8'h00, 8'h00, 1'b1, "rd_setup");
    check("rd_setup_addr", reg_addr, 8'h0A);
    bus_start();
    send_byte(8'h43, a);
    check("rd_id_ack", a, 1'b1);
    recv_byte(1'b0, rb, na);
    check("rd_byte0", rb, 8'h76);
    check("rd_byte0_released", na, 1'b0);
    recv_byte(1'b1, rb, na);
    check("rd_byte1", rb, 8'hAE);
    check("rd_byte1_released", na, 1'b0);
    check("rd_addr_inc", reg_addr, 8'h0B);
    ob = oe_n;
    for (int k = 0; k < 9; k++) begin
      scl_m = 1'b1; q();
      scl_m = 1'b0; q();
    end
    check("rd_ignore_oe", oe_n - ob, 0);
    bus_stop();
    q();
    check("rd_no_wr", wr_n - wb, 0);
    check("rd_active_after_stop", active, 1'b0);

    // STOP after 5 bits of a data byte
    wb = wr_n;
    bus_start();
    send_byte(8'h42, a);
    send_byte(8'h20, a);
    send_bits(8'hFF, 5);
    bus_stop();
    q();
    check("part_no_wr", wr_n - wb, 0);
    check("part_active", active, 1'b0);
    check("part_addr", reg_addr, 8'h20);

    // Reset mid-read while sda_oe is driving, then a fresh write
    write_txn(8'h42, 8'h0A, 0, 8'h00, 8'h00, 1'b1, "mr_setup");
    bus_start();
    send_byte(8'h43, a);
    check("mr_driving", sda_oe, 1'b1);
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("mr_oe_released", sda_oe, 1'b0);
    check("mr_active", active, 1'b0);
    check("mr_addr", reg_addr, 8'h00);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    q();
    wb = wr_n;
    write_txn(8'h42, 8'h05, 1, 8'h33, 8'h00, 1'b1, "mr_write");
    check("mr_wr_count", wr_n - wb, 1);
    check("mr_wr_addr", wr_a[6'(wb)], 8'h05);
    check("mr_wr_data", wr_d[6'(wb)], 8'h33);

    check("wr_pulse_width", wr_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
